// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-style CPU: control-word bit positions,
// opcodes and default widths used by the datapath and its sequencer.
package sap_pkg;

    localparam int SAP_DATA_W = 8;
    localparam int SAP_ADDR_W = 4;
    localparam int CTRL_W     = 15;

    localparam int CTRL_CP    = 14;
    localparam int CTRL_EP    = 13;
    localparam int CTRL_LP    = 12;
    localparam int CTRL_N_LMA = 11;
    localparam int CTRL_N_LMD = 10;
    localparam int CTRL_N_CE  = 9;
    localparam int CTRL_N_LR  = 8;
    localparam int CTRL_N_LI  = 7;
    localparam int CTRL_N_EI  = 6;
    localparam int CTRL_N_LA  = 5;
    localparam int CTRL_EA    = 4;
    localparam int CTRL_SU    = 3;
    localparam int CTRL_EU    = 2;
    localparam int CTRL_N_LB  = 1;
    localparam int CTRL_N_LO  = 0;

    // Every active-low strobe high and every active-high enable low.
    localparam logic [CTRL_W-1:0] CTRL_IDLE = 15'b000111111100011;

    typedef enum logic [3:0] {
        OP_HLT = 4'd0,
        OP_NOP = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd3,
        OP_LDA = 4'd4,
        OP_OUT = 4'd5,
        OP_STA = 4'd6,
        OP_JMP = 4'd7
    } opcode_e;

endpackage

// File: rtl/sap_datapath_if.sv
// Sequencer/programmer-facing signal bundle of the SAP datapath.
interface sap_datapath_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) ();
    logic [14:0]       ctrl;
    logic [3:0]        opcode;
    logic              prog_en;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [DATA_W-1:0] out_val;
    logic [DATA_W-1:0] bus_dbg;
    logic              flag_c;
    logic              flag_z;
    logic              bus_conflict;
    logic              bus_err;

    modport master (
        output ctrl, prog_en, prog_we, prog_addr, prog_data,
        input  opcode, out_val, bus_dbg, flag_c, flag_z, bus_conflict, bus_err
    );

    modport slave (
        input  ctrl, prog_en, prog_we, prog_addr, prog_data,
        output opcode, out_val, bus_dbg, flag_c, flag_z, bus_conflict, bus_err
    );
endinterface

// File: rtl/sap_ram.sv
// 16x8 program/data RAM: asynchronous read, synchronous write, with the
// program-load port taking over the write path while prog_en is high.
module sap_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              prog_en,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    assign rd_data = mem[rd_addr];

    // Contents are never reset so a loaded program survives rst_n.
    always_ff @(posedge clk) begin
        if (prog_en) begin
            if (prog_we) begin
                mem[prog_addr] <= prog_data;
            end
        end else if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end
endmodule

// File: rtl/sap_datapath.sv
// SAP-style CPU datapath: executes the sequencer's control word on a shared
// 8-bit bus joining PC, MAR, MDR, RAM, IR, A, B, the ALU and the output register.
module sap_datapath
    import sap_pkg::*;
#(
    parameter int DATA_W = SAP_DATA_W,
    parameter int ADDR_W = SAP_ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    sap_datapath_if.slave dp
);
    logic [CTRL_W-1:0] c;
    logic [ADDR_W-1:0] pc, mar;
    logic [DATA_W-1:0] mdr, ir, a, b, out_reg;
    logic [DATA_W-1:0] bus, ram_rd, alu_r, alu_opnd;
    logic              alu_c, fc, fz, err, conflict, ram_we;
    logic              drv_ram, drv_ir, drv_pc, drv_a, drv_alu;
    logic [2:0]        drv_cnt;

    // Program mode looks exactly like an idle control word to the datapath.
    assign c = dp.prog_en ? CTRL_IDLE : dp.ctrl;

    assign drv_ram = ~c[CTRL_N_CE];
    assign drv_ir  = ~c[CTRL_N_EI];
    assign drv_pc  =  c[CTRL_EP];
    assign drv_a   =  c[CTRL_EA];
    assign drv_alu =  c[CTRL_EU];

    assign drv_cnt  = {2'b00, drv_ram} + {2'b00, drv_ir} + {2'b00, drv_pc}
                    + {2'b00, drv_a} + {2'b00, drv_alu};
    assign conflict = (drv_cnt > 3'd1);

    always_comb begin
        alu_opnd       = c[CTRL_SU] ? ~b : b;
        {alu_c, alu_r} = {1'b0, a} + {1'b0, alu_opnd} + {{DATA_W{1'b0}}, c[CTRL_SU]};
    end

    always_comb begin
        bus = '0;
        if (drv_ram) begin
            bus = ram_rd;
        end else if (drv_ir) begin
            bus = {{(DATA_W-4){1'b0}}, ir[3:0]};
        end else if (drv_pc) begin
            bus = {{(DATA_W-ADDR_W){1'b0}}, pc};
        end else if (drv_a) begin
            bus = a;
        end else if (drv_alu) begin
            bus = alu_r;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc      <= '0;
            mar     <= '0;
            mdr     <= '0;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            out_reg <= '0;
            fc      <= 1'b0;
            fz      <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (c[CTRL_LP]) begin
                pc <= bus[ADDR_W-1:0];
            end else if (c[CTRL_CP]) begin
                pc <= pc + 1'b1;
            end
            if (!c[CTRL_N_LMA]) mar     <= bus[ADDR_W-1:0];
            if (!c[CTRL_N_LMD]) mdr     <= bus;
            if (!c[CTRL_N_LI])  ir      <= bus;
            if (!c[CTRL_N_LB])  b       <= bus;
            if (!c[CTRL_N_LO])  out_reg <= bus;
            if (!c[CTRL_N_LA]) begin
                a <= bus;
                // Flags track only ALU results landing in A.
                if (c[CTRL_EU]) begin
                    fc <= alu_c;
                    fz <= (alu_r == '0);
                end
            end
            if (conflict) err <= 1'b1;
        end
    end

    // RAM stores are suppressed during reset so the program stays intact.
    assign ram_we = rst_n & ~c[CTRL_N_LR];

    sap_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk      (clk),
        .rd_addr  (mar),
        .rd_data  (ram_rd),
        .we       (ram_we),
        .wr_addr  (mar),
        .wr_data  (mdr),
        .prog_en  (dp.prog_en),
        .prog_we  (dp.prog_we),
        .prog_addr(dp.prog_addr),
        .prog_data(dp.prog_data)
    );

    assign dp.opcode       = ir[DATA_W-1 -: 4];
    assign dp.out_val      = out_reg;
    assign dp.bus_dbg      = bus;
    assign dp.flag_c       = fc;
    assign dp.flag_z       = fz;
    assign dp.bus_conflict = conflict;
    assign dp.bus_err      = err;
endmodule

// File: doc/sap_datapath.md
Name: sap_datapath

Overview:
- Datapath of the 8-bit SAP-style CPU. It sits directly downstream of the control sequencer.
- It consumes the 15-bit control word and executes it on a shared 8-bit bus: PC, MAR, MDR, 16x8 RAM, IR, A, B, add/sub ALU and output register.
- It returns the current opcode (IR[7:4]) upstream to the sequencer.
- It also provides a program-load port for RAM and observability outputs.

Parameters:
- DATA_W, 8, bus/register width.
- ADDR_W, 4, PC/MAR/RAM address width (RAM depth 2**ADDR_W).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- ctrl  in  15  control word; bits 14..0 = C_P, E_P, L_P, /L_MA, /L_MD, /CE, /L_R, /L_I, /E_I, /L_A, E_A, S_U, E_U, /L_B, /L_O. Changes on negedge, so it is stable at posedge.
- opcode  out  4  IR[7:4], to the sequencer.
- prog_en  in  1  program mode: while high, ctrl is treated as fully deasserted.
- prog_we  in  1  RAM write strobe; effective only when prog_en=1.
- prog_addr  in  ADDR_W  program write address.
- prog_data  in  DATA_W  program write data.
- out_val  out  DATA_W  output register.
- bus_dbg  out  DATA_W  current bus value.
- flag_c  out  1  carry from the last ALU write to A.
- flag_z  out  1  zero from the last ALU write to A.
- bus_conflict  out  1  combinational: more than one bus driver enabled.
- bus_err  out  1  sticky: bus_conflict was seen at some posedge.

Behaviour:
- Reset (rst_n=0 at posedge):
  - PC, MAR, MDR, IR, A, B, OUT, flag_c, flag_z and bus_err clear to 0.
  - RAM contents are retained.
  - The prog port still writes during reset.
- Bus (combinational):
  - Drivers: /CE -> RAM[MAR]; /E_I -> {0000, IR[3:0]}; E_P -> {0000, PC}; E_A -> A; E_U -> ALU.
  - Multiple drivers: fixed priority RAM > IR > PC > A > ALU, and bus_conflict=1.
  - No driver enabled: bus = 0x00.
- ALU (combinational):
  - S_U=0: {c, r} = A + B.
  - S_U=1: {c, r} = A + ~B + 1.
  - 8-bit result wraps.
- PC:
  - L_P=1: PC <= bus[3:0]. L_P wins over C_P when both are set.
  - Else C_P=1: PC <= PC + 1, wrapping 0xF -> 0x0.
- Loads on posedge, each from the bus when its active-low strobe = 0:
  - /L_MA -> MAR <= bus[3:0].
  - /L_MD -> MDR.
  - /L_I -> IR.
  - /L_A -> A.
  - /L_B -> B.
  - /L_O -> OUT.
- Flags:
  - flag_c <= c and flag_z <= (r==0) only when /L_A=0 and E_U=1 in the same cycle.
  - All other loads hold the flags.
- RAM:
  - Asynchronous read of RAM[MAR].
  - /L_R=0 at posedge: RAM[MAR] <= MDR.
  - The write uses pre-edge MAR and MDR, so loading MDR and writing in the same cycle writes the old MDR.
  - A read in the same cycle as a write returns the old data.
  - Loading MAR in a cycle reads using the old MAR.
- A self-load (E_A and /L_A together) leaves A unchanged.
- bus_err <= 1 at any posedge where bus_conflict=1; cleared only by reset.
- Program mode (prog_en=1):
  - All registers hold.
  - prog_we writes RAM[prog_addr] <= prog_data.
  - Leaving program mode resumes with registers unchanged.
- Latency: every register update is visible one posedge after the control word is presented. opcode follows IR with no extra delay.

Decomposition:
- Shared package sap_pkg contains:
  - Control-bit index constants CTRL_* (14..0).
  - Opcode constants: HLT=0, NOP=1, ADD=2, SUB=3, LDA=4, OUT=5, STA=6, JMP=7.
  - DATA_W/ADDR_W defaults and the reset/idle control word 15'b000111111100011.
- One natural sub-module: sap_ram (16x8, async read, sync write, second write port for programming, with the prog_en mux inside).
- Bus mux, ALU and registers stay in sap_datapath.

Test Plan:
1. Reset: 2 cycles of rst_n=0 with ctrl=idle -> all outputs 0, bus_dbg=0x00, bus_conflict=0; RAM[3]=0x55 preloaded is still 0x55 after reset.
2. Fetch: prog RAM[0]=0x4A.
   - E_P + /L_MA -> MAR=0.
   - C_P -> PC=1.
   - /CE + /L_I -> IR=0x4A, opcode=4.
   - /E_I + /L_MA -> MAR=0xA.
3. ADD overflow: A=0xF0, RAM[MAR]=0x20.
   - /CE + /L_B -> B=0x20.
   - E_U + /L_A -> A=0x10, flag_c=1, flag_z=0.
   - /L_O + E_A -> out_val=0x10.
4. SUB to zero: A=0x05, B=0x05; S_U + E_U + /L_A -> A=0x00, flag_z=1, flag_c=1. Next plain /L_A from RAM leaves the flags unchanged.
5. STA: A=0x3C, MAR=0xE.
   - E_A + /L_MD -> MDR=0x3C.
   - /L_R -> RAM[0xE]=0x3C; /CE then reads 0x3C.
   - Same-cycle /L_MD + /L_R writes the old MDR.
6. PC edges and conflict:
   - PC=0xF with C_P -> PC=0.
   - IR=0x47, /E_I + L_P + C_P -> PC=7.
   - E_P + E_A together -> bus_dbg=PC, bus_conflict=1, and bus_err=1 after the edge; bus_err clears only on reset.
